param_victim_cache: RTL and testbench
=====================================

Name: param_victim_cache

Overview:
- Fully associative write-back victim cache between the L1 cache and physical memory.
- Generalised successor of the fixed 8-entry victim buffer: way count, address width and line width are parameters.
- Read hits use swap semantics: the entry is returned to L1 and invalidated.
- The controller FSM, age-based true LRU and dirty write-back are integrated in one block; no external control module is needed.

Parameters:
NUM_WAYS, 8, number of fully associative entries (power of 2, 2..32)
ADDR_W, 16, byte address width
LINE_W, 256, line width in bits
OFFSET_W, 5, line offset bits; tag width TAG_W = ADDR_W-OFFSET_W

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
mem_read  in  1  L1 miss lookup request, held until mem_resp
mem_write  in  1  L1 eviction install request, held until mem_resp
mem_dirty  in  1  line being installed is dirty
mem_address  in  ADDR_W  request address; offset bits ignored
mem_wdata  in  LINE_W  line being installed
mem_resp  out  1  one-cycle completion pulse
mem_rdata  out  LINE_W  returned line, valid when mem_resp=1
mem_hit  out  1  with mem_resp: request hit in the victim cache
pmem_read  out  1  memory line read, held until pmem_resp
pmem_write  out  1  memory line write, held until pmem_resp
pmem_address  out  ADDR_W  line address, offset bits zero
pmem_wdata  out  LINE_W  write-back data
pmem_rdata  in  LINE_W  memory read data
pmem_resp  in  1  memory completion

Behaviour:
- Reset (rst_n=0 at posedge):
  - all valid and dirty bits clear; way i age = i
  - FSM returns to IDLE; mem_resp, mem_hit, pmem_read and pmem_write are 0
  - pmem_address and mem_rdata are 0
  - reset mid-transaction abandons it silently; outputs drop next cycle.
- Tag match: hit_i = valid_i & (tag_i == mem_address[ADDR_W-1:OFFSET_W]). At most one way hits.
- FSM states: IDLE, LOOKUP, WRITEBACK, FETCH, RESP.
- IDLE:
  - a request is accepted when mem_read|mem_write, go to LOOKUP
  - mem_read and mem_write asserted together: write takes priority.
- LOOKUP, read hit:
  - latch the way's data and dirty bit into the response register
  - invalidate the way and make it LRU
  - go to RESP with mem_hit=1. mem_resp appears 2 cycles after the request is first seen.
  - A dirty line leaving via read-hit transfers ownership to L1 (no write-back).
- LOOKUP, read miss: go to FETCH with pmem_read=1. No allocation.
- LOOKUP, write hit: overwrite data; dirty = old dirty | mem_dirty; way becomes MRU; go to RESP.
- LOOKUP, write miss, target selection:
  - if any way is invalid, the target is the lowest-index invalid way
  - else the target is the way with age NUM_WAYS-1 (LRU)
  - LRU target dirty: go to WRITEBACK, with pmem_address={tag,0} and pmem_wdata=line registered on entry
  - otherwise install immediately and go to RESP.
- WRITEBACK: hold pmem_write until pmem_resp. Then install the new line (valid=1, dirty=mem_dirty, MRU) and go to RESP.
- FETCH: hold pmem_read until pmem_resp. Register pmem_rdata into mem_rdata and go to RESP with mem_hit=0.
- RESP: mem_resp=1 for exactly one cycle, then IDLE. Next request is accepted no earlier than the cycle after mem_resp.
- LRU ages, width clog2(NUM_WAYS):
  - on MRU update of way k, ways with age < age_k increment and way k becomes 0
  - on invalidate of way k, ways with age > age_k decrement and way k becomes NUM_WAYS-1
  - ages always form a permutation.
- pmem_read and pmem_write are never asserted together. pmem_address and pmem_wdata are stable while the strobe is high.
- Request inputs change only after mem_resp. The block does not re-sample the address mid-transaction.

Optional Feature:
VC_FLUSH_EN:
- Defined: adds port flush (in, 1) and flush_done (out, 1).
- flush is accepted only in IDLE and has priority over mem_read/mem_write.
- The FSM walks ways 0..NUM_WAYS-1. Each valid dirty way is written back (WRITEBACK handshake) and has its dirty bit cleared. Valid bits are kept.
- flush_done pulses one cycle after the last way is checked.
- Undefined: no flush ports and no flush states.

Test Plan:
- Reset, then mem_read 0x1240 -> pmem_read with pmem_address 0x1240; pmem_resp with data 0xAA.. -> mem_resp=1, mem_hit=0, mem_rdata 0xAA.., no entry allocated.
- Install 8 clean lines at tags 0..7, then read tag 3 -> mem_hit=1, correct data; re-read tag 3 -> miss (entry invalidated).
- Fill 8 dirty lines, touch tag 0 with a write hit, install a 9th line -> pmem_write of tag 1's line with its data, then install; a 10th install evicts tag 2.
- Write hit with mem_dirty=0 on a dirty line -> line stays dirty; a later eviction of that line produces a write-back.
- Deassert rst_n in the middle of a pmem_write wait -> next cycle pmem_write=0 and all entries invalid; reads miss.
- VC_FLUSH_EN: 3 dirty and 2 clean valid lines, pulse flush -> exactly 3 pmem_write transactions in way order, then flush_done, then read hits still return the lines.

Source files
------------

// File: rtl/param_victim_cache_if.sv
// Bus bundle between L1, the victim cache and physical memory.
// The slave modport is the cache's view; the master modport is the environment's view.
interface param_victim_cache_if #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 256
);
    logic              mem_read;
    logic              mem_write;
    logic              mem_dirty;
    logic [ADDR_W-1:0] mem_address;
    logic [LINE_W-1:0] mem_wdata;
    logic              mem_resp;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_hit;
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    modport slave (
        input  mem_read, mem_write, mem_dirty, mem_address, mem_wdata, pmem_rdata, pmem_resp,
        output mem_resp, mem_rdata, mem_hit, pmem_read, pmem_write, pmem_address, pmem_wdata
    );

    modport master (
        output mem_read, mem_write, mem_dirty, mem_address, mem_wdata, pmem_rdata, pmem_resp,
        input  mem_resp, mem_rdata, mem_hit, pmem_read, pmem_write, pmem_address, pmem_wdata
    );
endinterface

// File: rtl/param_victim_cache.sv
// Fully associative write-back victim cache with swap-on-read-hit and age-based true LRU.
// Optional VC_FLUSH_EN adds flush/flush_done to write back every dirty way without invalidating.
module param_victim_cache #(
    parameter int NUM_WAYS = 8,
    parameter int ADDR_W   = 16,
    parameter int LINE_W   = 256,
    parameter int OFFSET_W = 5
) (
    input logic clk,
    input logic rst_n,
    param_victim_cache_if.slave bus
`ifdef VC_FLUSH_EN
    ,
    input  logic flush,
    output logic flush_done
`endif
);
    localparam int TAG_W = ADDR_W - OFFSET_W;
    localparam int AGE_W = $clog2(NUM_WAYS);
    localparam logic [AGE_W-1:0] LAST_WAY = AGE_W'(NUM_WAYS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WRITEBACK,
        FETCH,
        RESP
`ifdef VC_FLUSH_EN
        ,
        FLUSH_CHECK,
        FLUSH_WB,
        FLUSH_DONE
`endif
    } state_e;

    state_e              state_q, state_d;
    logic [TAG_W-1:0]    tag_q  [NUM_WAYS];
    logic [TAG_W-1:0]    tag_d  [NUM_WAYS];
    logic [LINE_W-1:0]   data_q [NUM_WAYS];
    logic [LINE_W-1:0]   data_d [NUM_WAYS];
    logic [AGE_W-1:0]    age_q  [NUM_WAYS];
    logic [AGE_W-1:0]    age_d  [NUM_WAYS];
    logic [NUM_WAYS-1:0] valid_q, valid_d;
    logic [NUM_WAYS-1:0] dirty_q, dirty_d;
    logic [LINE_W-1:0]   rdata_q, rdata_d;
    logic                hit_q, hit_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [LINE_W-1:0]   pwdata_q, pwdata_d;
    logic [AGE_W-1:0]    target_q, target_d;
    logic [TAG_W-1:0]    req_tag_q, req_tag_d;
    logic                req_write_q, req_write_d;
    logic                req_dirty_q, req_dirty_d;
`ifdef VC_FLUSH_EN
    logic [AGE_W-1:0]    flush_idx_q, flush_idx_d;
`endif

    logic             hit_any;
    logic [AGE_W-1:0] hit_idx;
    logic             inv_found;
    logic [AGE_W-1:0] inv_idx;
    logic [AGE_W-1:0] lru_idx;
    logic [AGE_W-1:0] victim_idx;
    logic             do_mru, do_inv, install;
    logic [AGE_W-1:0] upd_way, inst_way;
    logic             unused_addr_bits;

    assign unused_addr_bits = ^bus.mem_address[OFFSET_W-1:0];

    // Tag match and write-miss victim choice: lowest invalid way first, else the oldest way.
    always_comb begin
        hit_any   = 1'b0;
        hit_idx   = '0;
        inv_found = 1'b0;
        inv_idx   = '0;
        lru_idx   = '0;
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (valid_q[i] && (tag_q[i] == req_tag_q)) begin
                hit_any = 1'b1;
                hit_idx = AGE_W'(i);
            end
            if (!valid_q[i] && !inv_found) begin
                inv_found = 1'b1;
                inv_idx   = AGE_W'(i);
            end
            if (age_q[i] == LAST_WAY) begin
                lru_idx = AGE_W'(i);
            end
        end
        victim_idx = inv_found ? inv_idx : lru_idx;
    end

    always_comb begin
        state_d     = state_q;
        tag_d       = tag_q;
        data_d      = data_q;
        age_d       = age_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        rdata_d     = rdata_q;
        hit_d       = hit_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        target_d    = target_q;
        req_tag_d   = req_tag_q;
        req_write_d = req_write_q;
        req_dirty_d = req_dirty_q;
`ifdef VC_FLUSH_EN
        flush_idx_d = flush_idx_q;
`endif
        do_mru   = 1'b0;
        do_inv   = 1'b0;
        install  = 1'b0;
        upd_way  = target_q;
        inst_way = target_q;

        case (state_q)
            IDLE: begin
                hit_d = 1'b0;
`ifdef VC_FLUSH_EN
                if (flush) begin
                    flush_idx_d = '0;
                    state_d     = FLUSH_CHECK;
                end else
`endif
                if (bus.mem_read || bus.mem_write) begin
                    req_tag_d   = bus.mem_address[ADDR_W-1:OFFSET_W];
                    req_write_d = bus.mem_write;
                    req_dirty_d = bus.mem_dirty;
                    state_d     = LOOKUP;
                end
            end
            LOOKUP: begin
                if (req_write_q) begin
                    if (hit_any) begin
                        data_d[hit_idx]  = bus.mem_wdata;
                        dirty_d[hit_idx] = dirty_q[hit_idx] | req_dirty_q;
                        do_mru           = 1'b1;
                        upd_way          = hit_idx;
                        hit_d            = 1'b1;
                        state_d          = RESP;
                    end else begin
                        target_d = victim_idx;
                        if (valid_q[victim_idx] && dirty_q[victim_idx]) begin
                            paddr_d  = {tag_q[victim_idx], {OFFSET_W{1'b0}}};
                            pwdata_d = data_q[victim_idx];
                            state_d  = WRITEBACK;
                        end else begin
                            install  = 1'b1;
                            inst_way = victim_idx;
                            state_d  = RESP;
                        end
                    end
                end else if (hit_any) begin
                    // Swap: ownership of the line, dirty or not, moves back to L1.
                    rdata_d          = data_q[hit_idx];
                    valid_d[hit_idx] = 1'b0;
                    dirty_d[hit_idx] = 1'b0;
                    do_inv           = 1'b1;
                    upd_way          = hit_idx;
                    hit_d            = 1'b1;
                    state_d          = RESP;
                end else begin
                    paddr_d = {req_tag_q, {OFFSET_W{1'b0}}};
                    state_d = FETCH;
                end
            end
            WRITEBACK: begin
                if (bus.pmem_resp) begin
                    install  = 1'b1;
                    inst_way = target_q;
                    state_d  = RESP;
                end
            end
            FETCH: begin
                if (bus.pmem_resp) begin
                    rdata_d = bus.pmem_rdata;
                    state_d = RESP;
                end
            end
            RESP: begin
                hit_d   = 1'b0;
                state_d = IDLE;
            end
`ifdef VC_FLUSH_EN
            FLUSH_CHECK: begin
                if (valid_q[flush_idx_q] && dirty_q[flush_idx_q]) begin
                    paddr_d  = {tag_q[flush_idx_q], {OFFSET_W{1'b0}}};
                    pwdata_d = data_q[flush_idx_q];
                    state_d  = FLUSH_WB;
                end else if (flush_idx_q == LAST_WAY) begin
                    state_d = FLUSH_DONE;
                end else begin
                    flush_idx_d = flush_idx_q + AGE_W'(1);
                end
            end
            FLUSH_WB: begin
                if (bus.pmem_resp) begin
                    dirty_d[flush_idx_q] = 1'b0;
                    if (flush_idx_q == LAST_WAY) begin
                        state_d = FLUSH_DONE;
                    end else begin
                        flush_idx_d = flush_idx_q + AGE_W'(1);
                        state_d     = FLUSH_CHECK;
                    end
                end
            end
            FLUSH_DONE: begin
                state_d = IDLE;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

        if (install) begin
            tag_d[inst_way]   = req_tag_q;
            data_d[inst_way]  = bus.mem_wdata;
            valid_d[inst_way] = 1'b1;
            dirty_d[inst_way] = req_dirty_q;
            do_mru            = 1'b1;
            upd_way           = inst_way;
        end

        // Ages stay a permutation: only the ways on one side of the touched way shift by one.
        if (do_mru) begin
            for (int i = 0; i < NUM_WAYS; i++) begin
                if (age_q[i] < age_q[upd_way]) begin
                    age_d[i] = age_q[i] + AGE_W'(1);
                end
            end
            age_d[upd_way] = '0;
        end else if (do_inv) begin
            for (int i = 0; i < NUM_WAYS; i++) begin
                if (age_q[i] > age_q[upd_way]) begin
                    age_d[i] = age_q[i] - AGE_W'(1);
                end
            end
            age_d[upd_way] = LAST_WAY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            dirty_q     <= '0;
            rdata_q     <= '0;
            hit_q       <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            target_q    <= '0;
            req_tag_q   <= '0;
            req_write_q <= 1'b0;
            req_dirty_q <= 1'b0;
            for (int i = 0; i < NUM_WAYS; i++) begin
                age_q[i] <= AGE_W'(i);
            end
`ifdef VC_FLUSH_EN
            flush_idx_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
            rdata_q     <= rdata_d;
            hit_q       <= hit_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            target_q    <= target_d;
            req_tag_q   <= req_tag_d;
            req_write_q <= req_write_d;
            req_dirty_q <= req_dirty_d;
            age_q       <= age_d;
`ifdef VC_FLUSH_EN
            flush_idx_q <= flush_idx_d;
`endif
        end
    end

    // Line storage is qualified by valid bits, so it needs no reset.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    assign bus.mem_resp     = (state_q == RESP);
    assign bus.mem_hit      = hit_q;
    assign bus.mem_rdata    = rdata_q;
    assign bus.pmem_read    = (state_q == FETCH);
    assign bus.pmem_address = paddr_q;
    assign bus.pmem_wdata   = pwdata_q;
`ifdef VC_FLUSH_EN
    assign bus.pmem_write   = (state_q == WRITEBACK) || (state_q == FLUSH_WB);
    assign flush_done       = (state_q == FLUSH_DONE);
`else
    assign bus.pmem_write   = (state_q == WRITEBACK);
`endif
endmodule

// File: tb/tb_param_victim_cache.sv
// Directed self-checking bench for param_victim_cache (default 8 ways, 16-bit address, 256-bit lines).
// With VC_FLUSH_EN defined it also exercises the flush walk.
module tb_param_victim_cache;
    localparam int NUM_WAYS = 8;
    localparam int ADDR_W   = 16;
    localparam int LINE_W   = 256;
    localparam int OFFSET_W = 5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    param_victim_cache_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

`ifdef VC_FLUSH_EN
    logic flush;
    logic flush_done;
`endif

    param_victim_cache #(
        .NUM_WAYS(NUM_WAYS),
        .ADDR_W  (ADDR_W),
        .LINE_W  (LINE_W),
        .OFFSET_W(OFFSET_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
`ifdef VC_FLUSH_EN
        ,
        .flush     (flush),
        .flush_done(flush_done)
`endif
    );

    int compare_count = 0;
    int fail_count    = 0;
    int both_seen     = 0;
    int rd_cnt, wb_cnt, resp_lat;
    logic              resp_seen, resp_hit;
    logic [LINE_W-1:0] resp_data, wb_data;
    logic [ADDR_W-1:0] rd_addr, wb_addr;

    function automatic logic [LINE_W-1:0] line_of(input int t, input logic [7:0] salt);
        return {8{salt, 8'h5A, 16'(t)}};
    endfunction

    function automatic logic [ADDR_W-1:0] addr_of(input int t);
        return ADDR_W'(t * (1 << OFFSET_W));
    endfunction

    task automatic checkOutput(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        compare_count++;
        assert (obs === exp) else begin
            fail_count++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issues one request, services any memory strobe immediately, and records the response.
    task automatic applyStimulus(input logic rd, input logic wr, input logic dty,
                                 input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] wdata,
                                 input logic [LINE_W-1:0] mem_data);
        rd_cnt    = 0;
        wb_cnt    = 0;
        resp_seen = 1'b0;
        resp_hit  = 1'b0;
        resp_data = '0;
        resp_lat  = 0;
        bus.mem_read    = rd;
        bus.mem_write   = wr;
        bus.mem_dirty   = dty;
        bus.mem_address = addr;
        bus.mem_wdata   = wdata;
        for (int c = 1; c <= 40 && !resp_seen; c++) begin
            @(posedge clk);
            @(negedge clk);
            bus.pmem_resp = 1'b0;
            if (bus.pmem_read && bus.pmem_write) both_seen++;
            if (bus.pmem_read) begin
                rd_cnt++;
                rd_addr        = bus.pmem_address;
                bus.pmem_rdata = mem_data;
                bus.pmem_resp  = 1'b1;
            end else if (bus.pmem_write) begin
                wb_cnt++;
                wb_addr       = bus.pmem_address;
                wb_data       = bus.pmem_wdata;
                bus.pmem_resp = 1'b1;
            end
            if (bus.mem_resp) begin
                resp_seen = 1'b1;
                resp_hit  = bus.mem_hit;
                resp_data = bus.mem_rdata;
                resp_lat  = c;
            end
        end
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.pmem_resp = 1'b0;
        checkOutput("resp_within_budget", resp_seen, 1'b1);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic doReset();
        rst_n           = 1'b0;
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.pmem_resp   = 1'b0;
`ifdef VC_FLUSH_EN
        flush           = 1'b0;
`endif
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int wb_sum;
        logic seen;
        bus.mem_dirty    = 1'b0;
        bus.mem_address  = '0;
        bus.mem_wdata    = '0;
        bus.pmem_rdata   = '0;
        doReset();
        $display("[TB] reset state");
        checkOutput("rst_mem_resp", bus.mem_resp, 1'b0);
        checkOutput("rst_mem_hit", bus.mem_hit, 1'b0);
        checkOutput("rst_pmem_read", bus.pmem_read, 1'b0);
        checkOutput("rst_pmem_write", bus.pmem_write, 1'b0);
        checkOutput("rst_pmem_address", bus.pmem_address, 16'h0000);
        checkOutput("rst_mem_rdata", bus.mem_rdata, '0);

        $display("[TB] read miss fetches from memory without allocating");
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h1240, '0, {32{8'hAA}});
        checkOutput("miss_rd_cnt", rd_cnt, 1);
        checkOutput("miss_pmem_addr", rd_addr, 16'h1240);
        checkOutput("miss_hit", resp_hit, 1'b0);
        checkOutput("miss_data", resp_data, {32{8'hAA}});
        checkOutput("miss_latency", resp_lat, 3);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h1240, '0, {32{8'h55}});
        checkOutput("miss_no_alloc_rd_cnt", rd_cnt, 1);
        checkOutput("miss_no_alloc_hit", resp_hit, 1'b0);

        $display("[TB] clean installs then swap read hit");
        wb_sum = 0;
        for (int t = 0; t < 8; t++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, addr_of(t), line_of(t, 8'hC1), '0);
            wb_sum += wb_cnt;
            if (t == 0) begin
                checkOutput("install_latency", resp_lat, 2);
                checkOutput("install_hit", resp_hit, 1'b0);
            end
        end
        checkOutput("clean_install_wb", wb_sum, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, addr_of(3), '0, '0);
        checkOutput("rdhit_hit", resp_hit, 1'b1);
        checkOutput("rdhit_data", resp_data, line_of(3, 8'hC1));
        checkOutput("rdhit_latency", resp_lat, 2);
        checkOutput("rdhit_no_pmem", rd_cnt, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, addr_of(3), '0, {32{8'h33}});
        checkOutput("reread_hit", resp_hit, 1'b0);
        checkOutput("reread_rd_cnt", rd_cnt, 1);

        $display("[TB] dirty fill, LRU eviction with write-back");
        doReset();
        for (int t = 0; t < 8; t++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, addr_of(t), line_of(t, 8'hD1), '0);
        end
        applyStimulus(1'b0, 1'b1, 1'b1, addr_of(0), line_of(0, 8'hE0), '0);
        checkOutput("wrhit_hit", resp_hit, 1'b1);
        checkOutput("wrhit_wb", wb_cnt, 0);
        applyStimulus(1'b0, 1'b1, 1'b1, addr_of(8), line_of(8, 8'hD1), '0);
        checkOutput("evict9_wb_cnt", wb_cnt, 1);
        checkOutput("evict9_wb_addr", wb_addr, 16'h0020);
        checkOutput("evict9_wb_data", wb_data, line_of(1, 8'hD1));
        checkOutput("evict9_latency", resp_lat, 3);
        applyStimulus(1'b0, 1'b1, 1'b1, addr_of(9), line_of(9, 8'hD1), '0);
        checkOutput("evict10_wb_addr", wb_addr, 16'h0040);
        checkOutput("evict10_wb_data", wb_data, line_of(2, 8'hD1));
        applyStimulus(1'b1, 1'b0, 1'b0, addr_of(8), '0, '0);
        checkOutput("tag8_hit", resp_hit, 1'b1);
        checkOutput("tag8_data", resp_data, line_of(8, 8'hD1));
        applyStimulus(1'b1, 1'b0, 1'b0, addr_of(0), '0, '0);
        checkOutput("tag0_overwritten", resp_data, line_of(0, 8'hE0));

        $display("[TB] clean write hit keeps a dirty line dirty");
        doReset();
        for (int t = 0; t < 8; t++) begin
            applyStimulus(1'b0, 1'b1, (t == 0), addr_of(t), line_of(t, 8'hB2), '0);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, addr_of(0), line_of(0, 8'hF0), '0);
        wb_sum = 0;
        for (int t = 1; t < 8; t++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, addr_of(t), line_of(t, 8'hB2), '0);
            wb_sum += wb_cnt;
        end
        checkOutput("touch_wb", wb_sum, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, addr_of(8), line_of(8, 8'hB2), '0);
        checkOutput("sticky_dirty_wb_cnt", wb_cnt, 1);
        checkOutput("sticky_dirty_wb_addr", wb_addr, 16'h0000);
        checkOutput("sticky_dirty_wb_data", wb_data, line_of(0, 8'hF0));
        applyStimulus(1'b0, 1'b1, 1'b0, addr_of(9), line_of(9, 8'hB2), '0);
        checkOutput("clean_evict_wb", wb_cnt, 0);

        $display("[TB] reset during a write-back wait");
        doReset();
        for (int t = 0; t < 8; t++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, addr_of(t), line_of(t, 8'hA7), '0);
        end
        bus.mem_write   = 1'b1;
        bus.mem_dirty   = 1'b1;
        bus.mem_address = addr_of(8);
        bus.mem_wdata   = line_of(8, 8'hA7);
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.pmem_write) seen = 1'b1;
        end
        checkOutput("midrst_wb_started", seen, 1'b1);
        checkOutput("midrst_wb_data", bus.pmem_wdata, line_of(0, 8'hA7));
        rst_n         = 1'b0;
        bus.mem_write = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("midrst_pmem_write", bus.pmem_write, 1'b0);
        checkOutput("midrst_mem_resp", bus.mem_resp, 1'b0);
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, addr_of(0), '0, {32{8'h11}});
        checkOutput("midrst_tag0_miss", resp_hit, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, addr_of(7), '0, {32{8'h77}});
        checkOutput("midrst_tag7_miss", resp_hit, 1'b0);
        checkOutput("midrst_tag7_data", resp_data, {32{8'h77}});

`ifdef VC_FLUSH_EN
        begin
            logic [ADDR_W-1:0] fl_addr [3];
            int fl_n;
            logic done;
            $display("[TB] flush writes back dirty ways in order");
            doReset();
            for (int t = 0; t < 5; t++) begin
                applyStimulus(1'b0, 1'b1, (t % 2 == 0), addr_of(t), line_of(t, 8'h9F), '0);
            end
            fl_n = 0;
            done = 1'b0;
            flush = 1'b1;
            for (int c = 0; c < 200 && !done; c++) begin
                @(posedge clk);
                @(negedge clk);
                flush         = 1'b0;
                bus.pmem_resp = 1'b0;
                if (bus.pmem_write) begin
                    if (fl_n < 3) fl_addr[fl_n] = bus.pmem_address;
                    fl_n++;
                    bus.pmem_resp = 1'b1;
                end
                if (flush_done) done = 1'b1;
            end
            bus.pmem_resp = 1'b0;
            @(posedge clk);
            @(negedge clk);
            checkOutput("flush_done_seen", done, 1'b1);
            checkOutput("flush_wb_count", fl_n, 3);
            checkOutput("flush_addr0", fl_addr[0], 16'h0000);
            checkOutput("flush_addr1", fl_addr[1], 16'h0040);
            checkOutput("flush_addr2", fl_addr[2], 16'h0080);
            applyStimulus(1'b1, 1'b0, 1'b0, addr_of(2), '0, '0);
            checkOutput("flush_keeps_valid", resp_hit, 1'b1);
            checkOutput("flush_keeps_data", resp_data, line_of(2, 8'h9F));
        end
`endif

        checkOutput("pmem_exclusive", both_seen, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
        $finish;
    end
endmodule
